// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the staggered reset release sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    S_ASSERT  = 3'd0,
    S_SYNC    = 3'd1,
    S_HOLD    = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Width of the shared hold/stagger counter: wide enough for the larger count.
  function automatic int cnt_w(input int hold_cycles, input int stagger);
    int m;
    m = (hold_cycles > stagger) ? hold_cycles : stagger;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic int idx_w(input int num_out);
    return (num_out < 1) ? 1 : $clog2(num_out + 1);
  endfunction

endpackage

// File: rtl/reset_release_seq_sync.sv
// Async-clear, sync-release chain for the deassertion edge of rst.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sync_pre,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  // sync_pre is the value the last stage loads on the coming edge.
  assign sync_pre = chain[STAGES-2];
  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/reset_release_seq.sv
// Reset sequencer: immediate assertion, synchronized release, programmable hold,
// then staggered per-output deassertion; also handles software reset requests.
module reset_release_seq
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int NUM_OUT     = 3,
  parameter int STAGGER     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               ready
);

  localparam int CW = cnt_w(HOLD_CYCLES, STAGGER);
  localparam int IW = idx_w(NUM_OUT);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] ONE  = NUM_OUT'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          sync_pre;
  logic          sync_out;
  logic          sw_accept;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  reset_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .sync_pre(sync_pre),
    .sync_out(sync_out)
  );

  // Requests only count once the synchronized release has happened.
  assign sw_accept = sw_rst_req &&
                     ((state == S_HOLD) || (state == S_RELEASE) || (state == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_ASSERT;
      cnt        <= '0;
      idx        <= '0;
      rst_n_out  <= '0;
      ready      <= 1'b0;
      sw_rst_ack <= 1'b0;
    end else begin
      sw_rst_ack <= 1'b0;
      if (sw_accept) begin
        state      <= S_HOLD;
        cnt        <= '0;
        idx        <= '0;
        rst_n_out  <= '0;
        ready      <= 1'b0;
        sw_rst_ack <= 1'b1;
      end else begin
        case (state)
          S_ASSERT: state <= S_SYNC;
          S_SYNC: begin
            // Leave on the edge where the last synchronizer stage becomes 1.
            if (sync_pre || sync_out) begin
              state <= S_HOLD;
              cnt   <= '0;
            end
          end
          S_HOLD: begin
            if (cnt == HOLD_LAST) begin
              rst_n_out[0] <= 1'b1;
              cnt          <= '0;
              if (NUM_OUT == 1) begin
                state <= S_DONE;
              end else begin
                idx   <= IW'(1);
                state <= S_RELEASE;
              end
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          S_RELEASE: begin
            if (cnt == STAG_LAST) begin
              rst_n_out <= rst_n_out | (ONE << idx);
              cnt       <= '0;
              if (idx >= IDX_LAST) begin
                state <= S_DONE;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          S_DONE:  ready <= 1'b1;
          default: state <= S_ASSERT;
        endcase
      end
    end
  end

endmodule
